// File: rtl/ysyx_23060025_trap_ctrl.sv
// Trap sequencer: takes one exception/mret request at a time, issues the
// mepc/mcause write for traps, then hands the redirect target to the IFU.
module ysyx_23060025_trap_ctrl #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  exc_valid_i,
  output logic                  exc_ready_o,
  input  logic [1:0]            exc_type_i,
  input  logic [DATA_WIDTH-1:0] exc_pc_i,
  output logic [2:0]            csr_type_o,
  output logic [DATA_WIDTH-1:0] csr_mepc_o,
  output logic [DATA_WIDTH-1:0] csr_mcause_o,
  input  logic [DATA_WIDTH-1:0] csr_mtvec_i,
  input  logic [DATA_WIDTH-1:0] csr_mepc_i,
  output logic                  redir_valid_o,
  input  logic                  redir_ready_i,
  output logic [DATA_WIDTH-1:0] redir_pc_o,
  output logic                  flush_o,
  output logic                  busy_o,
  output logic [31:0]           trap_cnt_o
);

  localparam logic [2:0] CSR_ECALL = 3'b001;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_COMMIT   = 2'd1;
  localparam logic [1:0] S_REDIRECT = 2'd2;

  localparam logic [1:0] EXC_ECALL   = 2'd0;
  localparam logic [1:0] EXC_MRET    = 2'd1;
  localparam logic [1:0] EXC_ILLEGAL = 2'd2;
  localparam logic [1:0] EXC_EBREAK  = 2'd3;

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [1:0]            type_q;
  logic [DATA_WIDTH-1:0] mepc_q;
  logic [DATA_WIDTH-1:0] mcause_q;
  logic [DATA_WIDTH-1:0] redir_pc_q;
  logic [31:0]           trap_cnt_q;
  logic                  accept;
  logic                  is_trap_q;

  function automatic logic [DATA_WIDTH-1:0] align4(input logic [DATA_WIDTH-1:0] a);
    return {a[DATA_WIDTH-1:2], 2'b00};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] cause_of(input logic [1:0] t);
    logic [DATA_WIDTH-1:0] c;
    c = '0;
    unique case (t)
      EXC_ECALL:   c[3:0] = 4'd11;
      EXC_EBREAK:  c[3:0] = 4'd3;
      EXC_ILLEGAL: c[3:0] = 4'd2;
      default:     c[3:0] = 4'd0;
    endcase
    return c;
  endfunction

  assign accept    = (state == S_IDLE) && exc_valid_i;
  assign is_trap_q = (type_q != EXC_MRET);

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:     if (exc_valid_i) state_nxt = S_COMMIT;
      S_COMMIT:   state_nxt = S_REDIRECT;
      S_REDIRECT: if (redir_ready_i) state_nxt = S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= S_IDLE;
      type_q     <= EXC_ECALL;
      mepc_q     <= '0;
      mcause_q   <= '0;
      redir_pc_q <= '0;
      trap_cnt_q <= '0;
    end else begin
      state <= state_nxt;
      // mepc/mcause only move for traps so an mret leaves the last write visible
      if (accept) begin
        type_q <= exc_type_i;
        if (exc_type_i != EXC_MRET) begin
          mepc_q   <= exc_pc_i;
          mcause_q <= cause_of(exc_type_i);
        end
      end
      // CSR targets are sampled here only; later CSR changes cannot disturb the redirect
      if (state == S_COMMIT) begin
        redir_pc_q <= is_trap_q ? align4(csr_mtvec_i) : align4(csr_mepc_i);
        if (is_trap_q) trap_cnt_q <= trap_cnt_q + 32'd1;
      end
    end
  end

  assign exc_ready_o   = (state == S_IDLE);
  assign busy_o        = (state != S_IDLE);
  assign redir_valid_o = (state == S_REDIRECT);
  assign redir_pc_o    = redir_pc_q;
  assign flush_o       = (state == S_COMMIT) && !reset;
  assign csr_type_o    = ((state == S_COMMIT) && is_trap_q && !reset) ? CSR_ECALL : 3'b000;
  assign csr_mepc_o    = mepc_q;
  assign csr_mcause_o  = mcause_q;
  assign trap_cnt_o    = trap_cnt_q;

endmodule
